// File: rtl/mips_muldiv_pkg.sv
// mips_pkg: shared opcode/state encodings for the mips_muldiv multiply/divide unit
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input logic [2:0] op);
        return op == MD_MULT || op == MD_DIV;
    endfunction

    function automatic logic md_is_arith(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// muldiv_step: one combinational shift-add multiply or restoring divide iteration
// Ports:
//   div_mode - 1 = restoring divide step, 0 = shift-add multiply step
//   part     - partial value {upper, lower}; multiply: {product hi, remaining multiplier},
//              divide: {partial remainder, remaining dividend bits}
//   opnd     - multiplicand or divisor magnitude
//   nxt      - next partial value (divide: bit 0 left clear for the quotient bit)
//   q        - quotient bit produced by this divide step (0 in multiply mode)
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode,
    input  logic [2*WIDTH-1:0] part,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] nxt,
    output logic               q
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;

    // Multiply: add multiplicand when the current multiplier bit is set, keep the carry
    assign sum  = {1'b0, part[2*WIDTH-1:WIDTH]} + {1'b0, part[0] ? opnd : {WIDTH{1'b0}}};
    // Divide: shifted remainder can reach WIDTH+1 bits; the difference always fits WIDTH
    assign shl  = part[2*WIDTH-1:WIDTH-1];
    assign diff = shl[WIDTH-1:0] - opnd;
    assign q    = div_mode & (shl >= {1'b0, opnd});
    assign nxt  = div_mode ? {q ? diff : shl[WIDTH-1:0], part[WIDTH-2:0], 1'b0}
                           : {sum, part[WIDTH-1:1]};

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   start, op  - launch request and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   a, b       - rs / rt operands
//   flush      - squash any in-flight operation
//   busy       - operation in progress, HI/LO not yet valid
//   done       - one-cycle pulse after HI/LO written by a multiply/divide
//   hi, lo     - HI/LO registers
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, step_nx, prod;
    logic [WIDTH-1:0]   opnd, abs_a, abs_b, quo, rem;
    logic               div_mode, neg_lo, neg_hi, div_zero;
    logic               step_q, signed_op, idle_start, launch;

    assign signed_op  = md_is_signed(op);
    assign abs_a      = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b      = (signed_op && b[WIDTH-1]) ? -b : b;
    assign idle_start = state == S_IDLE && start && !flush;
    assign launch     = idle_start && md_is_arith(op);
    assign busy       = state != S_IDLE;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (div_mode),
        .part     (acc),
        .opnd     (opnd),
        .nxt      (step_nx),
        .q        (step_q)
    );

    // Sign correction; divide by zero leaves the all-ones quotient the hardware produced
    // regardless of sign, while the remainder (|a|) gets the dividend sign back
    assign prod = neg_lo ? -acc : acc;
    assign quo  = div_zero ? {WIDTH{1'b1}} : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush)                 state_nx = S_IDLE;
        else if (state == S_IDLE)  state_nx = launch ? S_CALC : S_IDLE;
        else if (state == S_CALC)  state_nx = (cnt == CNT_W'(WIDTH - 1)) ? S_FIX : S_CALC;
        else                       state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                acc      <= {{WIDTH{1'b0}}, abs_a};
                opnd     <= abs_b;
                div_mode <= op[1];
                neg_lo   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi   <= signed_op & a[WIDTH-1];
                div_zero <= op[1] & (b == '0);
                cnt      <= '0;
            end
            if (idle_start && op == MD_MTHI) hi <= a;
            if (idle_start && op == MD_MTLO) lo <= a;
            if (state == S_CALC && !flush) begin
                acc <= step_nx | {{(2*WIDTH-1){1'b0}}, step_q};
                cnt <= cnt + 1'b1;
            end
            if (state == S_FIX && !flush) begin
                hi   <= div_mode ? rem : prod[2*WIDTH-1:WIDTH];
                lo   <= div_mode ? quo : prod[WIDTH-1:0];
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: randomized scoreboard bench for mips_muldiv against an arithmetic model
module tb_mips_muldiv;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mips_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic with MIPS truncating division semantics
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint          sx, sy, sp;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h = 32'd0;
        l = 32'd0;
        case (o)
            3'd0: begin sp = sx * sy; {h, l} = sp; end
            3'd1: begin up = {32'd0, x} * {32'd0, y}; {h, l} = up; end
            3'd2: begin
                if (y == 32'd0) begin l = 32'hFFFF_FFFF; h = x; end
                else begin l = 32'(sx / sy); h = 32'(sx % sy); end
            end
            3'd3: begin
                if (y == 32'd0) begin l = 32'hFFFF_FFFF; h = x; end
                else begin l = x / y; h = x % y; end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pickv();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        wait_idle();
        model(o, x, y, eh, el);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        sb.push_back('{eh, el, cyc + 34});
        mhi = eh;
        mlo = el;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                chk("hi", {32'd0, hi}, {32'd0, mon_e.hi});
                chk("lo", {32'd0, lo}, {32'd0, mon_e.lo});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MD_MULT,  32'hFFFF_FFFD, 32'd5);
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(MD_DIVU,  32'd100, 32'd7);
        issue(MD_DIVU,  32'd5, 32'd0);
        issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd0);
        issue(MD_DIV,   32'h8000_0000, 32'd0);

        // MTHI then MTLO on back-to-back idle cycles
        wait_idle();
        start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        chk("mthi_done", {63'd0, done}, 64'd0);
        op = MD_MTLO; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234_5678);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        chk("mtlo_done", {63'd0, done}, 64'd0);
        mhi = 32'h1234_5678;
        mlo = 32'h9ABC_DEF0;

        // Reserved opcode does nothing
        start = 1'b1; op = 3'd6; a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        chk("nop_busy", {63'd0, busy}, 64'd0);
        chk("nop_hi", {32'd0, hi}, {32'd0, mhi});
        chk("nop_lo", {32'd0, lo}, {32'd0, mlo});

        // Flush wins over a simultaneous start in idle
        start = 1'b1; flush = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_hi", {32'd0, hi}, {32'd0, mhi});
        chk("flush_idle_busy", {63'd0, busy}, 64'd0);

        // Flush mid-multiply, with a competing start in the same cycle
        start = 1'b1; op = MD_MULTU; a = 32'h0001_2345; b = 32'h0006_789A;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1; start = 1'b1; op = MD_MTLO; a = 32'h5555_AAAA;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hi", {32'd0, hi}, {32'd0, mhi});
        chk("flush_lo", {32'd0, lo}, {32'd0, mlo});
        repeat (40) @(negedge clk);
        chk("flush_later_hi", {32'd0, hi}, {32'd0, mhi});

        // Start pulsed while busy is ignored; only the divide result appears
        issue(MD_DIV, 32'hFFFF_FC18, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; op = MD_MULTU; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;

        // Asynchronous reset mid-divide
        wait_idle();
        start = 1'b1; op = MD_DIV; a = 32'h7777_7777; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        mhi = 32'd0;
        mlo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) issue(3'($urandom_range(0, 3)), pickv(), pickv());

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
